multi_ch_enable_sync_rx: RTL and testbench
==========================================

Name: multi_ch_enable_sync_rx

Overview:
Destination-side receiver for a multi-channel, toggle-enable bus synchronizer. It takes NUM_CH asynchronous request toggles and their quasi-static data buses from source domains, synchronizes each toggle and captures the word into a per-channel holding register. A round-robin arbiter then serializes the words onto one valid/ready stream tagged with a channel ID. An ack toggle per channel is returned to the source side for its own synchronizer, which gives lossless back-pressure instead of a fixed-period enable.

Parameters:
DATA_WIDTH, 32, width of each channel's data bus
NUM_CH, 4, number of independent source channels (>=1)
SYNC_STAGES, 2, flops in each toggle synchronizer chain (>=2)
CH_W, derived localparam = max(1, clog2(NUM_CH)), width of channel ID

Ports:
i_dest_clk  in  1  destination clock (only clock in block)
i_dest_rst_n  in  1  asynchronous active-low reset
i_src_req_tgl  in  NUM_CH  async request toggles, one per channel; a level change = new word
i_src_data  in  NUM_CH*DATA_WIDTH  async data, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]; stable from toggle until matching ack
o_dest_ack_tgl  out  NUM_CH  toggles once per word released from holding register
o_dest_valid  out  1  output word valid
i_dest_ready  in  1  consumer accepts when valid & ready
o_dest_data  out  DATA_WIDTH  output word
o_dest_ch  out  CH_W  source channel of o_dest_data
o_overrun  out  NUM_CH  sticky per-channel protocol-violation flag
i_clr_overrun  in  1  synchronous clear of all o_overrun bits

Behaviour:
- Reset (async assert, sync release): sync chains, prev-level flops, hold regs, full flags, o_dest_ack_tgl, o_dest_valid, o_dest_data, o_dest_ch, o_overrun and the RR pointer all go to 0.
- Per channel: SYNC_STAGES-flop chain on i_src_req_tgl[k]; prev flop holds last synced level. new_pulse[k] = sync_out XOR prev, exactly one cycle per toggle.
- Latency: toggle meeting setup before edge 1 -> sync_out changes after edge SYNC_STAGES -> hold captured and full[k]=1 after edge SYNC_STAGES+1 -> o_dest_valid=1 after edge SYNC_STAGES+2 (if output slot is free and the channel is granted).
- Capture: on new_pulse[k], hold[k] <= data slice k if the slot is free this cycle. full_next = capture | (full & ~drain). If a slot drains and receives a pulse in the same cycle, the word is captured and there is no overrun.
- Overrun: new_pulse & full & ~drain sets o_overrun[k]. The word is dropped, hold[k] is kept, and no ack is sent. Set wins over i_clr_overrun in the same cycle.
- Output register is loadable when !o_dest_valid or (o_dest_valid & i_dest_ready).
- When loadable and any full[k] is set, the arbiter grants one channel. That cycle: o_dest_data <= hold[g], o_dest_ch <= g, o_dest_valid <= 1, full[g] <= 0, o_dest_ack_tgl[g] flips.
- When loadable and no channel is full, o_dest_valid <= 0.
- Back-to-back: sustained throughput is one word per cycle when ready is held high.
- Arbiter: round-robin. Search starts at ptr; after granting g, ptr <= (g+1) mod NUM_CH. ptr resets to 0, so ch0 has highest priority. A channel with a pending word waits at most NUM_CH-1 grants.
- While o_dest_valid=1 and i_dest_ready=0, o_dest_data and o_dest_ch stay stable.
- NUM_CH=1: o_dest_ch is constantly 0 and the arbiter degenerates to a pass-through.
- Reset mid-operation: in-flight words are discarded. Source and destination domains must be reset together, because a source toggle left at 1 across a destination-only reset produces one spurious word.
- The ack toggle is registered (no combinational path) so it is safe to synchronize in the source domain.

Decomposition:
- Package cdc_sync_pkg: MIN_SYNC_STAGES=2 constant, ch_width(n) function returning max(1, clog2(n)).
- Sub-module toggle_sync_rx (sync chain, prev flop, pulse output; parameter SYNC_STAGES), instantiated NUM_CH times in a generate loop.
- Holding registers, arbiter and output stage stay in the top module.

Test Plan:
- Single word: reset, then toggle ch2 with data 0xDEADBEEF and ready=1 -> valid after edge 4 (SYNC_STAGES=2), data 0xDEADBEEF, ch=2, ack_tgl[2] flips 0->1 exactly once.
- All channels at once: toggle ch0..ch3 in the same cycle with data 0x10..0x13 and ready=1 -> four consecutive valid cycles with ch order 0,1,2,3; all four ack bits flip.
- Back-pressure: ready=0, send ch1=0xA5A5A5A5 -> valid held with stable data for 20 cycles, no ack_tgl[1] change while the holding slot stays full; raise ready -> one transfer.
- Overrun: ready=0, send ch0 twice (second before ack returns) with 0x1 then 0x2 -> o_overrun[0]=1; output delivers 0x1 only. i_clr_overrun clears the flag.
- Round-robin fairness: ch0 and ch3 each re-toggle immediately after every ack for 100 words -> grants alternate 0,3,0,3, with neither channel granted twice in a row while the other is pending.
- Reset mid-transfer: assert i_dest_rst_n low while ch1 is full and valid=1 -> all outputs 0 immediately; after release with both domains reset, no spurious valid.

Source files
------------

// File: rtl/multi_ch_enable_sync_rx_pkg.sv
// Shared constants and helpers for the toggle-handshake CDC receivers.
package cdc_sync_pkg;

    localparam int MIN_SYNC_STAGES = 2;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_ch_enable_sync_rx_toggle_sync_rx.sv
// Toggle synchronizer: flop chain into the destination clock plus an edge
// detector that emits a single-cycle pulse for every level change.
module toggle_sync_rx
    import cdc_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async_tgl,
    output logic o_pulse
);

    localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async_tgl};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_pulse = r_sync[STAGES-1] ^ r_prev;

endmodule

// File: rtl/multi_ch_enable_sync_rx.sv
// Multi-channel toggle-handshake receiver: per-channel capture into holding
// registers, round-robin merge onto one valid/ready stream, ack toggle back.
module multi_ch_enable_sync_rx
    import cdc_sync_pkg::*;
#(
    parameter  int DATA_WIDTH  = 32,
    parameter  int NUM_CH      = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic                         i_dest_clk,
    input  logic                         i_dest_rst_n,
    input  logic [NUM_CH-1:0]            i_src_req_tgl,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_src_data,
    output logic [NUM_CH-1:0]            o_dest_ack_tgl,
    output logic                         o_dest_valid,
    input  logic                         i_dest_ready,
    output logic [DATA_WIDTH-1:0]        o_dest_data,
    output logic [CH_W-1:0]              o_dest_ch,
    output logic [NUM_CH-1:0]            o_overrun,
    input  logic                         i_clr_overrun
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

    logic [NUM_CH-1:0]     w_pulse;
    logic [NUM_CH-1:0]     w_full;
    logic [NUM_CH-1:0]     w_drain;
    logic [DATA_WIDTH-1:0] w_hold [NUM_CH];

    logic                  r_dest_valid;
    logic [DATA_WIDTH-1:0] r_dest_data;
    logic [CH_W-1:0]       r_dest_ch;
    logic [CH_W-1:0]       r_ptr;

    logic                  w_load;
    logic                  w_any_full;
    logic [CH_W-1:0]       w_grant;
    logic [CH_W:0]         w_ptr_inc;
    logic [CH_W-1:0]       w_ptr_next;

    assign w_load = ~r_dest_valid | i_dest_ready;

    // First full slot at or after r_ptr, wrapping modulo NUM_CH.
    always_comb begin : rr_arbiter
        logic [CH_W:0] idx;
        w_any_full = 1'b0;
        w_grant    = '0;
        idx        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, r_ptr} + (CH_W+1)'(i);
            if (idx >= NUM_CH_L) begin
                idx = idx - NUM_CH_L;
            end
            if (!w_any_full && w_full[idx[CH_W-1:0]]) begin
                w_any_full = 1'b1;
                w_grant    = idx[CH_W-1:0];
            end
        end
    end

    assign w_ptr_inc  = {1'b0, w_grant} + (CH_W+1)'(1);
    assign w_ptr_next = (w_ptr_inc >= NUM_CH_L) ? '0 : w_ptr_inc[CH_W-1:0];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DATA_WIDTH-1:0] w_src_word;
        logic                  w_capture;
        logic                  w_ovr_set;
        logic                  r_full;
        logic [DATA_WIDTH-1:0] r_hold;
        logic                  r_ack_tgl;
        logic                  r_overrun;

        assign w_src_word = i_src_data[gi*DATA_WIDTH +: DATA_WIDTH];

        toggle_sync_rx #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .i_clk       (i_dest_clk),
            .i_rst_n     (i_dest_rst_n),
            .i_async_tgl (i_src_req_tgl[gi]),
            .o_pulse     (w_pulse[gi])
        );

        assign w_drain[gi] = w_load & w_any_full & (w_grant == CH_W'(gi));
        // A slot draining this cycle can accept a new word without overrun.
        assign w_capture   = w_pulse[gi] & (~r_full | w_drain[gi]);
        assign w_ovr_set   = w_pulse[gi] & r_full & ~w_drain[gi];

        always_ff @(posedge i_dest_clk or negedge i_dest_rst_n) begin
            if (!i_dest_rst_n) begin
                r_full    <= 1'b0;
                r_hold    <= '0;
                r_ack_tgl <= 1'b0;
                r_overrun <= 1'b0;
            end else begin
                r_full    <= w_capture | (r_full & ~w_drain[gi]);
                if (w_capture) begin
                    r_hold <= w_src_word;
                end
                if (w_drain[gi]) begin
                    r_ack_tgl <= ~r_ack_tgl;
                end
                r_overrun <= w_ovr_set | (r_overrun & ~i_clr_overrun);
            end
        end

        assign w_full[gi]         = r_full;
        assign w_hold[gi]         = r_hold;
        assign o_dest_ack_tgl[gi] = r_ack_tgl;
        assign o_overrun[gi]      = r_overrun;
    end

    always_ff @(posedge i_dest_clk or negedge i_dest_rst_n) begin
        if (!i_dest_rst_n) begin
            r_dest_valid <= 1'b0;
            r_dest_data  <= '0;
            r_dest_ch    <= '0;
            r_ptr        <= '0;
        end else if (w_load) begin
            if (w_any_full) begin
                r_dest_valid <= 1'b1;
                r_dest_data  <= w_hold[w_grant];
                r_dest_ch    <= w_grant;
                r_ptr        <= w_ptr_next;
            end else begin
                r_dest_valid <= 1'b0;
            end
        end
    end

    assign o_dest_valid = r_dest_valid;
    assign o_dest_data  = r_dest_data;
    assign o_dest_ch    = r_dest_ch;

endmodule

// File: tb/tb_multi_ch_enable_sync_rx.sv
// Directed bench for multi_ch_enable_sync_rx: latency, ordering, back-pressure,
// overrun, round-robin fairness and mid-operation reset.
module tb_multi_ch_enable_sync_rx;

    localparam int DW  = 32;
    localparam int NCH = 4;
    localparam int SS  = 2;
    localparam int CHW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    req;
    logic [NCH*DW-1:0] data;
    logic [NCH-1:0]    ack;
    logic              valid;
    logic              ready;
    logic [DW-1:0]     dout;
    logic [CHW-1:0]    dch;
    logic [NCH-1:0]    ovr;
    logic              clr;

    int             checks = 0;
    int             errors = 0;
    logic [NCH-1:0] exp_ack;

    multi_ch_enable_sync_rx #(
        .DATA_WIDTH  (DW),
        .NUM_CH      (NCH),
        .SYNC_STAGES (SS)
    ) dut (
        .i_dest_clk     (clk),
        .i_dest_rst_n   (rst_n),
        .i_src_req_tgl  (req),
        .i_src_data     (data),
        .o_dest_ack_tgl (ack),
        .o_dest_valid   (valid),
        .i_dest_ready   (ready),
        .o_dest_data    (dout),
        .o_dest_ch      (dch),
        .o_overrun      (ovr),
        .i_clr_overrun  (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int ch, input logic [DW-1:0] w);
        data[ch*DW +: DW] = w;
        req[ch] = ~req[ch];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        data  = '0;
        step(2);
        rst_n   = 1'b1;
        exp_ack = '0;
        step(1);
    endtask

    logic [DW-1:0] cur_word [NCH];
    int            sent [NCH];
    logic [NCH-1:0] last_ack;
    int            rx;
    int            cyc;
    int            exp_rr_ch;

    initial begin
        rst_n = 1'b0; req = '0; data = '0; ready = 1'b1; clr = 1'b0; exp_ack = '0;
        for (int k = 0; k < NCH; k++) begin
            cur_word[k] = '0;
            sent[k]     = 0;
        end

        // Reset state
        step(3);
        chk("rst_valid", valid, 0);
        chk("rst_data", dout, 0);
        chk("rst_ch", dch, 0);
        chk("rst_ack", ack, 0);
        chk("rst_ovr", ovr, 0);
        rst_n = 1'b1;
        step(1);

        // Single word on ch2: valid after edge 4
        send(2, 32'hDEADBEEF);
        for (int i = 1; i <= 3; i++) begin
            step(1);
            chk("single_latency_valid", valid, 0);
        end
        step(1);
        chk("single_valid", valid, 1);
        chk("single_data", dout, 32'hDEADBEEF);
        chk("single_ch", dch, 2);
        exp_ack[2] = ~exp_ack[2];
        chk("single_ack", ack, exp_ack);
        step(1);
        chk("single_done_valid", valid, 0);
        chk("single_ack_once", ack, exp_ack);

        // All channels in the same cycle, fresh pointer -> order 0,1,2,3
        do_reset();
        for (int k = 0; k < NCH; k++) send(k, 32'h10 + DW'(k));
        step(3);
        for (int k = 0; k < NCH; k++) begin
            step(1);
            chk("all_valid", valid, 1);
            chk("all_ch", dch, k);
            chk("all_data", dout, 32'h10 + k);
            exp_ack[k] = ~exp_ack[k];
            chk("all_ack", ack, exp_ack);
        end
        step(1);
        chk("all_done_valid", valid, 0);

        // Back-pressure on ch1 (ptr now 0)
        ready = 1'b0;
        send(1, 32'hA5A5A5A5);
        step(4);
        chk("bp_valid", valid, 1);
        chk("bp_data", dout, 32'hA5A5A5A5);
        chk("bp_ch", dch, 1);
        exp_ack[1] = ~exp_ack[1];
        chk("bp_ack", ack, exp_ack);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("bp_hold_valid", valid, 1);
            chk("bp_hold_data", dout, 32'hA5A5A5A5);
            chk("bp_hold_ch", dch, 1);
            chk("bp_hold_ack", ack, exp_ack);
        end
        ready = 1'b1;
        step(1);
        chk("bp_xfer_valid", valid, 0);
        chk("bp_xfer_ack", ack, exp_ack);

        // Overrun on ch0: ch3 blocks the output (ptr=2 so ch3 wins), ch0 waits in hold
        ready = 1'b0;
        send(3, 32'h33);
        send(0, 32'h1);
        step(4);
        chk("ovr_blk_valid", valid, 1);
        chk("ovr_blk_ch", dch, 3);
        chk("ovr_blk_data", dout, 32'h33);
        exp_ack[3] = ~exp_ack[3];
        chk("ovr_blk_ack", ack, exp_ack);
        send(0, 32'h2);
        step(2);
        chk("ovr_not_yet", ovr, 0);
        step(1);
        chk("ovr_set", ovr, 4'b0001);
        chk("ovr_no_ack", ack, exp_ack);
        chk("ovr_stable_data", dout, 32'h33);
        ready = 1'b1;
        step(1);
        chk("ovr_deliver_valid", valid, 1);
        chk("ovr_deliver_data", dout, 32'h1);
        chk("ovr_deliver_ch", dch, 0);
        exp_ack[0] = ~exp_ack[0];
        chk("ovr_deliver_ack", ack, exp_ack);
        step(1);
        chk("ovr_dropped_valid", valid, 0);
        chk("ovr_sticky", ovr, 4'b0001);
        clr = 1'b1;
        step(1);
        chk("ovr_cleared", ovr, 0);
        clr = 1'b0;

        // Round-robin: ch0 and ch3 re-toggle after each ack; ptr=1 so ch3 goes first
        ready = 1'b1;
        last_ack  = ack;
        rx        = 0;
        cyc       = 0;
        exp_rr_ch = 3;
        cur_word[0] = 32'hC000_0000; sent[0] = 1; send(0, cur_word[0]);
        cur_word[3] = 32'hC300_0000; sent[3] = 1; send(3, cur_word[3]);
        while (rx < 100 && cyc < 3000) begin
            step(1);
            cyc++;
            if (valid) begin
                chk("rr_ch", dch, exp_rr_ch);
                chk("rr_data", dout, cur_word[exp_rr_ch]);
                exp_rr_ch = (exp_rr_ch == 3) ? 0 : 3;
                rx++;
            end
            if (ack[0] != last_ack[0]) begin
                last_ack[0] = ack[0];
                if (sent[0] < 50) begin
                    sent[0]++;
                    cur_word[0] = 32'hC000_0000 + DW'(sent[0]);
                    send(0, cur_word[0]);
                end
            end
            if (ack[3] != last_ack[3]) begin
                last_ack[3] = ack[3];
                if (sent[3] < 50) begin
                    sent[3]++;
                    cur_word[3] = 32'hC300_0000 + DW'(sent[3]);
                    send(3, cur_word[3]);
                end
            end
        end
        chk("rr_count", rx, 100);
        step(5);
        chk("rr_idle_valid", valid, 0);

        // Reset while ch1 is in the output register and another ch1 word is held
        ready = 1'b0;
        send(1, 32'h11);
        step(4);
        chk("mid_valid", valid, 1);
        chk("mid_ch", dch, 1);
        send(1, 32'h22);
        step(4);
        #2;
        rst_n = 1'b0;
        req   = '0;
        data  = '0;
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_data", dout, 0);
        chk("mid_rst_ch", dch, 0);
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_ovr", ovr, 0);
        step(2);
        rst_n   = 1'b1;
        ready   = 1'b1;
        exp_ack = '0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("post_rst_no_valid", valid, 0);
        end
        send(2, 32'h77);
        step(4);
        chk("post_rst_valid", valid, 1);
        chk("post_rst_data", dout, 32'h77);
        chk("post_rst_ch", dch, 2);
        exp_ack[2] = ~exp_ack[2];
        chk("post_rst_ack", ack, exp_ack);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
